// File: rtl/feistel_decrypter.sv
// Iterative inverse-Feistel decrypter for the 78-bit {tag, ciphertext} word.
// One round per clock under a 60-bit key, then the recovered plaintext is
// checked against the embedded 18-bit tag. Valid/ready handshakes on both sides.
module feistel_decrypter #(
  parameter int unsigned ROUNDS = 8  // 1..31, must match the encryption path
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [77:0] in_data,
  input  logic [59:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [59:0] out_data,
  output logic        out_tag_ok
);

  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    CHECK,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] l_q, l_d;
  logic [29:0] r_q, r_d;
  logic [17:0] t_q, t_d;
  logic [59:0] key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [59:0] out_data_q, out_data_d;
  logic        out_tag_ok_q, out_tag_ok_d;
  logic        out_valid_q, out_valid_d;
  logic [29:0] rk;

  function automatic logic [29:0] round_key(input logic [59:0] k, input logic [CW-1:0] i);
    logic [29:0] s;
    s = k[59:30] + 30'(i);
    return k[29:0] ^ s;
  endfunction

  function automatic logic [29:0] f_round(input logic [29:0] x, input logic [29:0] k);
    return ({x[26:0], x[29:27]} ^ k) + x;
  endfunction

  function automatic logic [17:0] tag_of(input logic [59:0] p);
    return p[17:0] ^ p[35:18] ^ p[53:36] ^ {12'b0, p[59:54]};
  endfunction

  // Next-state, datapath and handshake logic
  always_comb begin
    state_d      = state_q;
    l_d          = l_q;
    r_d          = r_q;
    t_d          = t_q;
    key_d        = key_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_tag_ok_d = out_tag_ok_q;
    out_valid_d  = out_valid_q;
    rk           = round_key(key_q, cnt_q);
    in_ready     = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          l_d     = in_data[59:30];
          r_d     = in_data[29:0];
          t_d     = in_data[77:60];
          key_d   = key;
          cnt_d   = LAST_ROUND;
          state_d = ROUND;
        end
      end
      ROUND: begin
        l_d = r_q ^ f_round(l_q, rk);
        r_d = l_q;
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d = cnt_q - CW'(1);
      end
      CHECK: begin
        out_data_d   = {l_q, r_q};
        out_tag_ok_d = (tag_of({l_q, r_q}) == t_q);
        out_valid_d  = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  // State and operand registers, asynchronously cleared
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      l_q          <= '0;
      r_q          <= '0;
      t_q          <= '0;
      key_q        <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_tag_ok_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      l_q          <= l_d;
      r_q          <= r_d;
      t_q          <= t_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_tag_ok_q <= out_tag_ok_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tag_ok = out_tag_ok_q;

endmodule

// File: tb/tb_feistel_decrypter.sv
// Bench for feistel_decrypter: one instance at ROUNDS=1, one at ROUNDS=8,
// checked every cycle against a transaction-level model fed by the stimulus.
module tb_feistel_decrypter;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [1:0]        in_valid, in_ready, out_valid, out_ready, out_tag_ok;
  logic [1:0][77:0]  in_data;
  logic [1:0][59:0]  key, out_data;

  always #5 Clk = ~Clk;

  feistel_decrypter #(.ROUNDS(1)) u_dut_r1 (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .key(key[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_tag_ok(out_tag_ok[0])
  );

  feistel_decrypter #(.ROUNDS(8)) u_dut_r8 (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .key(key[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_tag_ok(out_tag_ok[1])
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout want event within bound", nm);
  endtask

  // ---------------- specification-level functions ----------------
  function automatic logic [29:0] spec_f(input logic [29:0] x, input logic [29:0] k);
    logic [29:0] rot;
    rot = (x << 3) | (x >> 27);
    return (rot ^ k) + x;
  endfunction

  function automatic logic [59:0] encrypt(input logic [59:0] p, input logic [59:0] k,
                                          input int unsigned rounds);
    logic [29:0] l, r, ki, nl;
    l = p[59:30];
    r = p[29:0];
    for (int unsigned i = 0; i < rounds; i++) begin
      ki = k[29:0] ^ (k[59:30] + 30'(i));
      nl = r;
      r  = l ^ spec_f(r, ki);
      l  = nl;
    end
    return {l, r};
  endfunction

  function automatic logic [17:0] spec_tag(input logic [59:0] p);
    return p[17:0] ^ p[35:18] ^ p[53:36] ^ {12'b0, p[59:54]};
  endfunction

  function automatic logic [59:0] rand60();
    return 60'({$urandom(), $urandom()});
  endfunction

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [59:0] d;
    logic        ok;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  bit         m_busy[2];
  int         m_phase[2];
  int         m_acc[2];
  exp_t       m_pend[2];
  bit [59:0]  m_out[2];
  bit         m_ok[2];
  bit         m_valid[2];
  int         cyc = 0;

  function automatic int rounds_of(input int i);
    return (i == 0) ? 1 : 8;
  endfunction

  // Word moves: accept when idle, result appears ROUNDS+1 edges later,
  // released by out_ready once it is showing.
  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i]  = 1'b0;
        m_phase[i] = 0;
        m_out[i]   = '0;
        m_ok[i]    = 1'b0;
        m_valid[i] = 1'b0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (in_valid[i] === 1'b1) begin
            if (i == 0 && q0.size() > 0)      m_pend[i] = q0.pop_front();
            else if (i == 1 && q1.size() > 0) m_pend[i] = q1.pop_front();
            else fail($sformatf("model_queue_dut%0d", i));
            m_busy[i]  = 1'b1;
            m_phase[i] = 0;
            m_acc[i]++;
          end
        end else begin
          if (m_phase[i] == rounds_of(i)) begin
            m_out[i]   = m_pend[i].d;
            m_ok[i]    = m_pend[i].ok;
            m_valid[i] = 1'b1;
          end else if (m_phase[i] > rounds_of(i) && out_ready[i] === 1'b1) begin
            m_valid[i] = 1'b0;
            m_busy[i]  = 1'b0;
          end
          m_phase[i]++;
        end
      end
    end
  end

  function automatic logic [63:0] dut_outs(input int i);
    return {1'b0, in_ready[i], out_valid[i], out_tag_ok[i], out_data[i]};
  endfunction

  function automatic logic [63:0] model_outs(input int i);
    return {1'b0, ~m_busy[i], m_valid[i], m_ok[i], m_out[i]};
  endfunction

  bit stream_on = 1'b0;
  int last_acc  = -1;

  // Compare process: every cycle, both instances, plus stream spacing
  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++)
      chk($sformatf("outputs_dut%0d", i), dut_outs(i), model_outs(i));
    if (stream_on && !Rst && in_valid[1] && in_ready[1]) begin
      if (last_acc >= 0) chk("stream_spacing", 64'(cyc - last_acc), 64'd11);
      last_acc = cyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int i, input logic [77:0] d, input logic [59:0] k,
                      input logic [59:0] ed, input logic eok, input bit keep);
    int   a0;
    exp_t e;
    e.d  = ed;
    e.ok = eok;
    a0   = m_acc[i];
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    in_data[i]  = d;
    key[i]      = k;
    in_valid[i] = 1'b1;
    for (int n = 0; n < 100 && m_acc[i] == a0; n++) begin
      @(posedge Clk);
      #1;
    end
    if (m_acc[i] == a0) fail($sformatf("accept_timeout_dut%0d", i));
    if (!keep) begin
      in_valid[i] = 1'b0;
      in_data[i]  = 78'({$urandom(), $urandom(), $urandom()});
      key[i]      = rand60();
    end
  endtask

  task automatic wait_valid(input int i, output int lat);
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge Clk);
      if (out_valid[i] === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) fail($sformatf("valid_timeout_dut%0d", i));
  endtask

  function automatic logic [77:0] make_word(input logic [59:0] p, input logic [59:0] k,
                                            input int unsigned rounds);
    return {spec_tag(p), encrypt(p, k, rounds)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [59:0] p, k;
    int          lat;
    Rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    in_data   = '0;
    key       = '0;
    #2;
    chk("reset_state_dut0", dut_outs(0), {1'b0, 1'b1, 1'b0, 1'b0, 60'h0});
    chk("reset_state_dut1", dut_outs(1), {1'b0, 1'b1, 1'b0, 1'b0, 60'h0});
    @(posedge Clk);
    #1 Rst = 1'b0;

    // Pin the model with the hand-computed single-round vector
    chk("model_pin_encrypt", 64'(encrypt(60'h1, 60'h0, 1)), 64'h0000_0000_4000_0009);

    // Zero vector, ROUNDS=1
    out_ready[0] = 1'b1;
    send(0, 78'h0, 60'h0, 60'h0, 1'b1, 1'b0);
    wait_valid(0, lat);
    chk("zero_latency", 64'(lat), 64'd2);
    chk("zero_data", {3'b0, out_tag_ok[0], out_data[0]}, {3'b0, 1'b1, 60'h0});
    repeat (3) @(posedge Clk);
    #1;

    // Known vector and tag mismatch, ROUNDS=1
    send(0, {18'h00001, 60'h000000040000009}, 60'h0, 60'h1, 1'b1, 1'b0);
    wait_valid(0, lat);
    chk("known_data", {3'b0, out_tag_ok[0], out_data[0]}, {3'b0, 1'b1, 60'h1});
    repeat (3) @(posedge Clk);
    #1;
    send(0, {18'h00002, 60'h000000040000009}, 60'h0, 60'h1, 1'b0, 1'b0);
    wait_valid(0, lat);
    chk("mismatch_data", {3'b0, out_tag_ok[0], out_data[0]}, {3'b0, 1'b0, 60'h1});
    repeat (3) @(posedge Clk);
    #1;

    // Short random round-trip at ROUNDS=1, including key wrap
    for (int n = 0; n < 20; n++) begin
      p = rand60();
      k = rand60();
      if (n % 2 == 0) k[59:30] = 30'h3FFFFFFF;
      send(0, make_word(p, k, 1), k, p, 1'b1, 1'b0);
    end
    repeat (4) @(posedge Clk);
    #1;

    // Backpressure with busy-input pulses, ROUNDS=8
    out_ready[1] = 1'b0;
    p = rand60();
    k = rand60();
    send(1, make_word(p, k, 8), k, p, 1'b1, 1'b0);
    in_valid[1] = 1'b1;
    in_data[1]  = 78'({$urandom(), $urandom(), $urandom()});
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    in_valid[1] = 1'b0;
    wait_valid(1, lat);
    for (int n = 0; n < 20; n++) begin
      @(posedge Clk);
      #1;
      in_valid[1] = (n >= 5 && n < 8);
    end
    chk("bp_hold", {1'b0, in_ready[1], out_valid[1], out_tag_ok[1], out_data[1]},
        {1'b0, 1'b0, 1'b1, 1'b1, p});
    out_ready[1] = 1'b1;
    @(posedge Clk);
    #1;
    out_ready[1] = 1'b0;
    chk("bp_release", {1'b0, in_ready[1], out_valid[1], out_tag_ok[1], out_data[1]},
        {1'b0, 1'b1, 1'b0, 1'b1, p});
    repeat (3) @(posedge Clk);
    #1;

    // Asynchronous reset while holding a result in DONE
    p = rand60();
    k = rand60();
    send(1, make_word(p, k, 8), k, p, 1'b1, 1'b0);
    wait_valid(1, lat);
    chk("latency_r8", 64'(lat), 64'd9);
    @(posedge Clk);
    #3 Rst = 1'b1;
    #1;
    chk("async_reset_done", dut_outs(1), {1'b0, 1'b1, 1'b0, 1'b0, 60'h0});
    @(posedge Clk);
    #1 Rst = 1'b0;

    // Reset at round 4, then a clean word
    out_ready[1] = 1'b1;
    p = rand60();
    k = rand60();
    send(1, make_word(p, k, 8), k, p, 1'b1, 1'b0);
    repeat (3) @(posedge Clk);
    #3 Rst = 1'b1;
    #1;
    chk("async_reset_round", dut_outs(1), {1'b0, 1'b1, 1'b0, 1'b0, 60'h0});
    @(posedge Clk);
    #1 Rst = 1'b0;
    repeat (15) @(posedge Clk);
    #1;
    chk("no_valid_after_abort", 64'(out_valid[1]), 64'd0);
    p = rand60();
    k = rand60();
    send(1, make_word(p, k, 8), k, p, 1'b1, 1'b0);
    wait_valid(1, lat);
    chk("after_reset_latency", 64'(lat), 64'd9);
    chk("after_reset_data", {3'b0, out_tag_ok[1], out_data[1]}, {3'b0, 1'b1, p});
    repeat (3) @(posedge Clk);
    #1;

    // Back-to-back round-trip stream, ROUNDS=8
    last_acc  = -1;
    stream_on = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      p = rand60();
      k = rand60();
      if (n % 4 == 0) k[59:30] = 30'h3FFFFFFF;
      else if (n % 4 == 1) k[59:30] = 30'h3FFFFFFC;
      send(1, make_word(p, k, 8), k, p, 1'b1, 1'b1);
    end
    in_valid[1] = 1'b0;
    repeat (15) @(posedge Clk);
    #1;
    stream_on = 1'b0;
    chk("stream_drained", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/feistel_decrypter.md
# feistel_decrypter

Iterative decryption engine for the 78-bit encrypted word format that the encryption path produces from 60-bit plaintext. It runs one inverse Feistel round per clock under a 60-bit key, then checks the recovered plaintext against the embedded 18-bit tag. It sits under the top-level solver as the work-select `2'b01` (decrypt) path, with valid/ready handshakes on both sides.

## Interface
- `ROUNDS`, default 8: number of Feistel rounds. Legal range 1..31, and it must match the encryption path.
- `Clk` in 1: single clock, rising edge.
- `Rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: an encrypted word is offered.
- `in_ready` out 1: the block can accept a word (high only in IDLE).
- `in_data` in 78: encrypted word. Bits [77:60] are the tag; bits [59:0] are the ciphertext.
- `key` in 60: decryption key, sampled on acceptance.
- `out_valid` out 1: the result is held on the output ports.
- `out_ready` in 1: the consumer takes the result.
- `out_data` out 60: recovered plaintext.
- `out_tag_ok` out 1: 1 when the recomputed tag equals the received tag.

## Operation
- **Word split:**
  - Ciphertext halves are L = [59:30] and R = [29:0], 30 bits each.
  - Tag is T = in_data[77:60].
- **Round key:** K_i = key[29:0] ^ ((key[59:30] + i) mod 2^30), where i is the round index zero-extended to 30 bits.
- **Round function:** F(x,k) = ((rotl(x,3) ^ k) + x) mod 2^30. rotl is a 30-bit rotate left.
- **Encryption round (the definition this block inverts):** for i = 0..ROUNDS-1, L' = R and R' = L ^ F(R,K_i).
- **Decryption round:** for i = ROUNDS-1 down to 0, L_new = R ^ F(L,K_i) and R_new = L.
- **Tag:** tag(P) = P[17:0] ^ P[35:18] ^ P[53:36] ^ {12'b0, P[59:54]}.
- **FSM states:** IDLE, ROUND, CHECK, DONE.
  - **IDLE:** `in_ready`=1. When `in_valid`, on the edge: latch L, R, T and key; set the round counter to ROUNDS-1; go to ROUND.
  - **ROUND:** apply one decryption round per edge using the current counter value. If counter==0, go to CHECK; otherwise decrement the counter.
  - **CHECK:** on the edge, register `out_data`={L,R}, `out_tag_ok`=(tag({L,R})==T) and `out_valid`=1; go to DONE.
  - **DONE:** hold all outputs stable. On an edge with `out_ready`=1: `out_valid`←0 and go to IDLE. `out_ready` is ignored in every other state.
- **Input while busy:** `in_valid` outside IDLE is not accepted, and in_data/key changes have no effect (operands are latched).
- **No pass-through:** `in_ready` is never high in DONE, so an output handshake and an input acceptance cannot happen on the same edge.
- **Tag mismatch:** not an error state. The data is still delivered, with `out_tag_ok`=0.

## Timing
- **Reset values:**
  - `Rst` high forces IDLE immediately and asynchronously, from any state, including mid-ROUND or in DONE.
  - Outputs: `out_valid`=0, `out_data`=0, `out_tag_ok`=0, `in_ready`=1 (after Rst deasserts, IDLE).
  - Internal L/R/T/counter are cleared to 0.
- **Latency:**
  - Acceptance on edge A.
  - Rounds occupy edges A+1..A+ROUNDS.
  - The CHECK register update is on edge A+ROUNDS+1, so `out_valid` is first high in the cycle after edge A+ROUNDS+1.
- **Throughput:** with `out_ready` held at 1, the block returns to IDLE on edge A+ROUNDS+2 and can accept the next word on edge A+ROUNDS+3. This gives a minimum period of ROUNDS+3 cycles.
- **Output stability:** `out_data` and `out_tag_ok` change only on the CHECK edge and on reset.
- **Width rules:**
  - All 30-bit additions wrap modulo 2^30 (carry discarded).
  - key[59:30]+i wraps the same way.
  - With ROUNDS=1 only K_0 is used.

## Test plan
- **Reset:** assert `Rst` asynchronously mid-cycle -> all outputs go to reset values immediately; IDLE with `in_ready`=1 after release.
- **Zero vector:** ROUNDS=1, key=0, in_data=78'h0 -> `out_data`=60'h0 and `out_tag_ok`=1, with `out_valid` first high 2 cycles after acceptance.
- **Known vector:** ROUNDS=1, key=0, in_data={18'h00001, 60'h000000040000009} -> `out_data`=60'h000000000000001, `out_tag_ok`=1.
- **Tag mismatch:** same ciphertext as the known vector, tag 18'h00002 -> `out_data`=60'h000000000000001, `out_tag_ok`=0, and the FSM reaches DONE normally.
- **Backpressure and busy input:**
  - ROUNDS=8, hold `out_ready`=0 for 20 cycles -> outputs stay stable, `in_ready` stays 0, and `in_valid` pulses during ROUND and DONE are ignored.
  - Then assert `out_ready` -> one handshake, then IDLE.
- **Round-trip and reset mid-op:**
  - 1000 random plaintexts and keys at ROUNDS=8, encrypted by the bench model -> every `out_data` equals the plaintext with `out_tag_ok`=1, back-to-back spacing is exactly 11 cycles, and the key pattern covers key[59:30]=30'h3FFFFFFF to exercise wrap.
  - Apply `Rst` at round 4 -> no `out_valid`, and the next word decrypts correctly.
